// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle between the command decoder and seq_alu.
interface seq_alu_if #(
   parameter int WIDTH = 16
);
   logic                 start;
   logic [3:0]           command;
   logic [WIDTH-1:0]     inputA;
   logic [WIDTH-1:0]     inputB;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   result;
   logic                 error;
   logic                 overflow;
   logic                 divZero;

   modport master (
      output start, command, inputA, inputB,
      input  busy, done, result, error, overflow, divZero
   );

   modport slave (
      input  start, command, inputA, inputB,
      output busy, done, result, error, overflow, divZero
   );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub, iterative signed shift-add multiply,
// restoring unsigned divide/modulo, with a start/done handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// ADDSUB | one-cycle add/subtract with signed overflow detect
// MUL    | shift-add on operand magnitudes, one multiplier bit per clock
// FIX    | negate the magnitude product when operand signs differ
// DIVI   | restoring division, one quotient bit per clock (DIV and MOD)
// DONE   | result/flags valid for one cycle; may accept a new start
module seq_alu #(
   parameter int WIDTH = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   seq_alu_if.slave  bus
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0101;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_MOD = 4'b0100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDSUB,
      S_MUL,
      S_FIX,
      S_DIVI,
      S_DONE
   } state_t;

   state_t               state, state_nxt;
   logic [3:0]           cmd_q;
   logic [WIDTH-1:0]     op_a;      // ADD/SUB operand A, DIV dividend shifting into quotient
   logic [WIDTH-1:0]     op_b;      // ADD/SUB operand B, MUL multiplier magnitude, DIV divisor
   logic [WIDTH-1:0]     rem_q;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   mcand;
   logic                 sign_q;
   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   result_q;
   logic                 error_q;
   logic                 overflow_q;
   logic                 divzero_q;

   logic                 ready;
   logic                 accept;
   logic                 busy_c;
   logic                 done_c;

   // Operand magnitudes for the multiplier; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
   logic [WIDTH-1:0]     abs_a;
   logic [WIDTH-1:0]     abs_b;
   assign abs_a = bus.inputA[WIDTH-1] ? (~bus.inputA + 1'b1) : bus.inputA;
   assign abs_b = bus.inputB[WIDTH-1] ? (~bus.inputB + 1'b1) : bus.inputB;

   logic                 is_div_cmd;
   logic                 is_valid_cmd;
   assign is_div_cmd   = (bus.command == OP_DIV) || (bus.command == OP_MOD);
   assign is_valid_cmd = (bus.command == OP_ADD) || (bus.command == OP_SUB) ||
                         (bus.command == OP_MUL) || is_div_cmd;

   // Add/subtract: overflow is carry into the MSB xor carry out of it.
   logic                 cin;
   logic [WIDTH-1:0]     b_eff;
   logic [WIDTH-1:0]     low_sum;
   logic [WIDTH:0]       full_sum;
   logic                 add_ovf;
   assign cin      = (cmd_q == OP_SUB);
   assign b_eff    = cin ? ~op_b : op_b;
   assign low_sum  = {1'b0, op_a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]} + WIDTH'(cin);
   assign full_sum = {1'b0, op_a} + {1'b0, b_eff} + (WIDTH+1)'(cin);
   assign add_ovf  = low_sum[WIDTH-1] ^ full_sum[WIDTH];

   // Restoring division step.
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_diff;
   logic                 div_ge;
   logic [WIDTH-1:0]     rem_nxt;
   logic [WIDTH-1:0]     quot_nxt;
   assign div_shift = {rem_q, op_a[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, op_b};
   assign div_ge    = (div_shift >= {1'b0, op_b});
   assign rem_nxt   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign quot_nxt  = {op_a[WIDTH-2:0], div_ge};

   assign ready  = (state == S_IDLE) || (state == S_DONE);
   assign accept = ready && bus.start;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt = state;
      busy_c    = 1'b0;
      done_c    = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            done_c = (state == S_DONE);
            if (bus.start) begin
               if (!is_valid_cmd)                   state_nxt = S_DONE;
               else if (bus.command == OP_MUL)      state_nxt = S_MUL;
               else if (is_div_cmd)                 state_nxt = (bus.inputB == '0) ? S_DONE : S_DIVI;
               else                                 state_nxt = S_ADDSUB;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_ADDSUB: begin
            busy_c    = 1'b1;
            state_nxt = S_DONE;
         end
         S_MUL: begin
            busy_c    = 1'b1;
            state_nxt = (cnt == '0) ? S_FIX : S_MUL;
         end
         S_FIX: begin
            busy_c    = 1'b1;
            state_nxt = S_DONE;
         end
         S_DIVI: begin
            busy_c    = 1'b1;
            state_nxt = (cnt == '0) ? S_DONE : S_DIVI;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: operand capture at accept, iteration, and result/flag update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q      <= '0;
         op_a       <= '0;
         op_b       <= '0;
         rem_q      <= '0;
         acc        <= '0;
         mcand      <= '0;
         sign_q     <= 1'b0;
         cnt        <= '0;
         result_q   <= '0;
         error_q    <= 1'b0;
         overflow_q <= 1'b0;
         divzero_q  <= 1'b0;
      end else if (accept) begin
         cmd_q      <= bus.command;
         op_a       <= bus.inputA;
         op_b       <= (bus.command == OP_MUL) ? abs_b : bus.inputB;
         rem_q      <= '0;
         acc        <= '0;
         mcand      <= {{WIDTH{1'b0}}, abs_a};
         sign_q     <= bus.inputA[WIDTH-1] ^ bus.inputB[WIDTH-1];
         cnt        <= CW'(WIDTH - 1);
         error_q    <= 1'b0;
         overflow_q <= 1'b0;
         divzero_q  <= 1'b0;
         if (!is_valid_cmd) begin
            result_q <= '0;
            error_q  <= 1'b1;
         end else if (is_div_cmd && (bus.inputB == '0)) begin
            result_q  <= '1;
            divzero_q <= 1'b1;
            error_q   <= 1'b1;
         end
      end else begin
         case (state)
            S_ADDSUB: begin
               result_q   <= {{WIDTH{full_sum[WIDTH-1]}}, full_sum[WIDTH-1:0]};
               overflow_q <= add_ovf;
               error_q    <= add_ovf;
            end
            S_MUL: begin
               if (op_b[0]) acc <= acc + mcand;
               mcand <= {mcand[2*WIDTH-2:0], 1'b0};
               op_b  <= {1'b0, op_b[WIDTH-1:1]};
               cnt   <= cnt - 1'b1;
            end
            S_FIX: begin
               result_q <= sign_q ? (~acc + 1'b1) : acc;
            end
            S_DIVI: begin
               rem_q <= rem_nxt;
               op_a  <= quot_nxt;
               cnt   <= cnt - 1'b1;
               if (cnt == '0) begin
                  result_q <= (cmd_q == OP_DIV) ? {{WIDTH{1'b0}}, quot_nxt}
                                                : {{WIDTH{1'b0}}, rem_nxt};
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy     = busy_c;
   assign bus.done     = done_c;
   assign bus.result   = result_q;
   assign bus.error    = error_q;
   assign bus.overflow = overflow_q;
   assign bus.divZero  = divzero_q;

endmodule
